ahb_mtx_output_stage: RTL

- Slave-facing end of the L1 AHB bus matrix. The input-stage decoders raise a per-port select toward an output port; this block is what those selects drive.
- Arbitrates among NUM_IN input stages with round-robin priority.
- Drives the AHB-Lite address/control signals of one slave and routes write data in the data phase.
- Returns a per-input active flag that the decoders feed back as their active signal.

---
 rtl/ahb_mtx_output_stage_if.sv | 58 +++++
 rtl/ahb_mtx_output_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/ahb_mtx_output_stage_if.sv
// Bundle between the input-stage decoders, the output stage and its AHB-Lite slave.
// The output stage takes the master modport; the environment takes the slave modport.
interface ahb_mtx_output_stage_if #(
  parameter int NUM_IN = 3,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // Decoder side, one packed slot per input stage
  logic [NUM_IN-1:0]    sel_op;
  logic [NUM_IN*AW-1:0] addr_op;
  logic [NUM_IN*2-1:0]  trans_op;
  logic [NUM_IN-1:0]    write_op;
  logic [NUM_IN*3-1:0]  size_op;
  logic [NUM_IN*3-1:0]  burst_op;
  logic [NUM_IN*4-1:0]  prot_op;
  logic [NUM_IN-1:0]    mastlock_op;
  logic [NUM_IN*DW-1:0] wdata_op;
  logic [NUM_IN-1:0]    active_op;

  // Slave side
  logic          HSELM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [3:0]    HPROTM;
  logic          HMASTLOCKM;
  logic [DW-1:0] HWDATAM;
  logic          HREADYOUTM;
  logic          HREADYM;

  // Internal register view for observation
  logic [NUM_IN-1:0] dbg_addr_port;
  logic [NUM_IN-1:0] dbg_data_port;
  logic [IW-1:0]     dbg_last_grant;
  logic              dbg_dvalid;

  // Handshake: a slave transfer is accepted on a HCLK edge where HREADYM=1;
  // while HREADYM=0 every address/control output holds its value.
  modport master (
    input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, wdata_op, HREADYOUTM,
    output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
           HMASTLOCKM, HWDATAM, HREADYM,
           dbg_addr_port, dbg_data_port, dbg_last_grant, dbg_dvalid
  );

  modport slave (
    output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, wdata_op, HREADYOUTM,
    input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
           HMASTLOCKM, HWDATAM, HREADYM,
           dbg_addr_port, dbg_data_port, dbg_last_grant, dbg_dvalid
  );
endinterface

// File: rtl/ahb_mtx_output_stage.sv
// Slave-facing output stage of the L1 AHB matrix: round-robin arbitration among
// input stages, address/control muxing and data-phase write-data routing.
module ahb_mtx_output_stage #(
  parameter int NUM_IN = 3,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_mtx_output_stage_if.master bus
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0] addr_port;
  logic [NUM_IN-1:0] data_port;
  logic [IW-1:0]     last_grant;
  logic              dvalid;

  logic [NUM_IN-1:0] req;
  logic [IW-1:0]     reg_i;
  logic [IW-1:0]     win_i;
  logic [IW-1:0]     own_i;
  logic [IW-1:0]     data_i;
  logic [NUM_IN-1:0] own_oh;
  logic              win_found;
  logic              hold;
  logic              hready_m;

  assign hready_m = dvalid ? bus.HREADYOUTM : 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      req[i] = bus.sel_op[i] & bus.trans_op[i*2+1];
    end
  end

  // Owner of the registered address phase and of the data phase, as indices
  always_comb begin
    reg_i  = '0;
    data_i = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (addr_port[i]) reg_i = IW'(i);
      if (data_port[i]) data_i = IW'(i);
    end
  end

  // BUSY/SEQ both have trans[0]=1, so the burst test is a single bit.
  assign hold = bus.sel_op[reg_i] &
                (bus.trans_op[int'(reg_i)*2] | bus.mastlock_op[reg_i]);

  always_comb begin
    int cand;
    win_found = 1'b0;
    win_i     = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = (int'(last_grant) + k) % NUM_IN;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_i     = IW'(cand);
      end
    end
  end

  // Parking and holding both keep the registered owner
  assign own_i  = (hready_m && !hold && win_found) ? win_i : reg_i;
  assign own_oh = NUM_IN'(1) << own_i;

  always_comb begin
    bus.HSELM      = bus.sel_op[own_i];
    bus.HADDRM     = bus.addr_op[int'(own_i)*AW +: AW];
    bus.HTRANSM    = bus.HSELM ? bus.trans_op[int'(own_i)*2 +: 2] : 2'b00;
    bus.HWRITEM    = bus.write_op[own_i];
    bus.HSIZEM     = bus.size_op[int'(own_i)*3 +: 3];
    bus.HBURSTM    = bus.burst_op[int'(own_i)*3 +: 3];
    bus.HPROTM     = bus.prot_op[int'(own_i)*4 +: 4];
    bus.HMASTLOCKM = bus.mastlock_op[own_i];
    bus.active_op  = bus.HSELM ? own_oh : '0;
    bus.HWDATAM    = dvalid ? bus.wdata_op[int'(data_i)*DW +: DW] : '0;
    bus.HREADYM    = hready_m;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_port  <= NUM_IN'(1);
      data_port  <= '0;
      last_grant <= IW'(NUM_IN - 1);
      dvalid     <= 1'b0;
    end else if (hready_m) begin
      addr_port <= own_oh;
      data_port <= own_oh;
      dvalid    <= req[own_i];
      if (req[own_i]) last_grant <= own_i;
    end
  end

  assign bus.dbg_addr_port  = addr_port;
  assign bus.dbg_data_port  = data_port;
  assign bus.dbg_last_grant = last_grant;
  assign bus.dbg_dvalid     = dvalid;

endmodule
